avalon_sample_writer: RTL and testbench

//  CPU-to-stream audio path. Software writes samples through an Avalon-MM slave port. Samples are buffered in a FIFO.

---
 rtl/audio_pkg.sv | 30 +++
 rtl/sync_fifo.sv | 58 +++++
 rtl/avalon_sample_writer.sv | 108 ++++++++++
 tb/tb_avalon_sample_writer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the Avalon-MM sample writer.
//   DATA_SIZE_DEF : default sample width
//   REG_*         : register offsets on the slave port
//   CTRL_* / STAT_*: bit positions inside CTRL and STAT
//   mm_req_t      : chipselect-qualified slave request
package audio_pkg;
  localparam int DATA_SIZE_DEF = 28;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_CTRL = 2'd1;
  localparam logic [1:0] REG_STAT = 2'd2;
  localparam logic [1:0] REG_RSVD = 2'd3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_FLUSH  = 2;

  localparam int STAT_EMPTY    = 0;
  localparam int STAT_FULL     = 1;
  localparam int STAT_UNDERRUN = 2;
  localparam int STAT_OVERFLOW = 3;
  localparam int STAT_LVL_LSB  = 8;

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [1:0]  addr;
    logic [31:0] wdata;
  } mm_req_t;
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO.
//   push/pop  : enqueue din / dequeue head (caller guarantees legality)
//   flush     : empty in one cycle; overrides a push in the same cycle
//   dout      : head entry, valid whenever !empty
//   level     : fill count 0..DEPTH; full/empty derived from it
module sync_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic                        do_push;

  assign do_push = push & ~flush;

  // Pointers are AW bits wide so they wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (flush) begin
        // wr_ptr is not advancing under flush, so rd_ptr lands on it.
        rd_ptr <= wr_ptr;
        level  <= '0;
      end else begin
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        case ({do_push, pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
      end
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
endmodule

// File: rtl/avalon_sample_writer.sv
// CPU-to-stream audio sample writer.
//   Avalon-MM slave (chipselect/address/write/writedata/read/read_data) pushes
//   samples into a FIFO and exposes CTRL/STAT; samples leave on a valid/ready
//   source (out_valid/out_data/out_ready). irq is a registered level interrupt
//   for low water, overflow and underrun.
module avalon_sample_writer
  import audio_pkg::*;
#(
  parameter int DATA_SIZE  = DATA_SIZE_DEF,
  parameter int FIFO_DEPTH = 16,
  parameter int LOW_WATER  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 chipselect,
  input  logic [1:0]           address,
  input  logic                 write,
  input  logic [31:0]          writedata,
  input  logic                 read,
  output logic [31:0]          read_data,
  output logic                 out_valid,
  output logic [DATA_SIZE-1:0] out_data,
  input  logic                 out_ready,
  output logic                 irq
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  mm_req_t       req;
  logic          enable, irq_en, ovf, und;
  logic [LW-1:0] level;
  logic          full, empty;
  logic          push_req, push, pop, flush, ctrl_wr, stat_wr, low;
  logic [31:0]   rd_mux;
  logic          unused_wd;

  assign req = '{wr: chipselect & write, rd: chipselect & read,
                 addr: address, wdata: writedata};
  assign unused_wd = ^req.wdata;

  // enable is registered, so clearing it drops out_valid the next cycle,
  // and reset drops it asynchronously.
  assign out_valid = enable & ~empty;

  always_comb begin
    push_req = req.wr && (req.addr == REG_DATA);
    ctrl_wr  = req.wr && (req.addr == REG_CTRL);
    stat_wr  = req.wr && (req.addr == REG_STAT);
    flush    = ctrl_wr && req.wdata[CTRL_FLUSH];
    pop      = out_valid && out_ready;
    // A pop frees a slot in the same cycle, so full does not block then.
    push     = push_req && !flush && (!full || pop);
    low      = (level <= LW'(LOW_WATER));
  end

  sync_fifo #(.WIDTH(DATA_SIZE), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (req.wdata[DATA_SIZE-1:0]),
    .dout  (out_data),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    rd_mux = '0;
    case (req.addr)
      REG_CTRL: begin
        rd_mux[CTRL_EN]     = enable;
        rd_mux[CTRL_IRQ_EN] = irq_en;
      end
      REG_STAT: begin
        rd_mux[STAT_LVL_LSB +: 8] = 8'(level);
        rd_mux[STAT_OVERFLOW]     = ovf;
        rd_mux[STAT_UNDERRUN]     = und;
        rd_mux[STAT_FULL]         = full;
        rd_mux[STAT_EMPTY]        = empty;
      end
      default: rd_mux = '0;
    endcase
  end

  // Sticky flags: a new event in the same cycle as a W1C wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable    <= 1'b0;
      irq_en    <= 1'b0;
      ovf       <= 1'b0;
      und       <= 1'b0;
      irq       <= 1'b0;
      read_data <= '0;
    end else begin
      if (ctrl_wr) begin
        enable <= req.wdata[CTRL_EN];
        irq_en <= req.wdata[CTRL_IRQ_EN];
      end
      ovf <= (ovf & ~(stat_wr & req.wdata[STAT_OVERFLOW]))
           | (push_req & ~flush & full & ~pop);
      und <= (und & ~(stat_wr & req.wdata[STAT_UNDERRUN]))
           | (enable & empty & out_ready);
      irq <= irq_en & ((enable & low) | ovf | und);
      if (req.rd) read_data <= rd_mux;
    end
  end
endmodule

// File: tb/tb_avalon_sample_writer.sv
module tb_avalon_sample_writer;
  localparam int DW = 28, DEPTH = 16, LOW = 4;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          chipselect = 1'b0, write = 1'b0, read = 1'b0, out_ready = 1'b0;
  logic [1:0]    address = 2'd0;
  logic [31:0]   writedata = 32'd0;
  logic [31:0]   read_data;
  logic          out_valid, irq;
  logic [DW-1:0] out_data;

  always #5 clk = ~clk;

  avalon_sample_writer #(.DATA_SIZE(DW), .FIFO_DEPTH(DEPTH), .LOW_WATER(LOW)) dut (
    .clk(clk), .rst_n(rst_n), .chipselect(chipselect), .address(address),
    .write(write), .writedata(writedata), .read(read), .read_data(read_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .irq(irq));

  int total = 0, bad = 0;

  // Reference model: a queue of samples plus register/flag bits.
  logic [DW-1:0] q[$];
  bit            m_en, m_ie, m_ovf, m_und, m_irq;
  logic [31:0]   m_rd;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_reg(logic [1:0] a);
    logic [31:0] v;
    v = '0;
    if (a == 2'd1) begin
      v[0] = m_en; v[1] = m_ie;
    end else if (a == 2'd2) begin
      v[15:8] = 8'(q.size());
      v[3] = m_ovf; v[2] = m_und;
      v[1] = (q.size() == DEPTH); v[0] = (q.size() == 0);
    end
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    m_en = 0; m_ie = 0; m_ovf = 0; m_und = 0; m_irq = 0; m_rd = '0;
  endtask

  // One clock edge of the specified behaviour, from the pre-edge state.
  task automatic model_step();
    int n;
    bit pop, push_req, flush, wr;
    n        = q.size();
    wr       = chipselect && write;
    pop      = m_en && n > 0 && out_ready;
    push_req = wr && address == 2'd0;
    flush    = wr && address == 2'd1 && writedata[2];
    if (chipselect && read) m_rd = m_reg(address);
    m_irq = m_ie && ((m_en && n <= LOW) || m_ovf || m_und);
    if (wr && address == 2'd2) begin
      if (writedata[3]) m_ovf = 0;
      if (writedata[2]) m_und = 0;
    end
    if (m_en && n == 0 && out_ready) m_und = 1;
    if (pop) void'(q.pop_front());
    if (flush) q.delete();
    else if (push_req) begin
      if (q.size() < DEPTH) q.push_back(writedata[DW-1:0]);
      else m_ovf = 1;
    end
    if (wr && address == 2'd1) begin
      m_en = writedata[0]; m_ie = writedata[1];
    end
  endtask

  // Called at a negedge: drive, take one edge, then compare at the next negedge.
  task automatic cyc(bit cs, bit wr, bit rd, logic [1:0] a, logic [31:0] d, bit rdy);
    chipselect = cs; write = wr; read = rd; address = a; writedata = d; out_ready = rdy;
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(m_en && q.size() > 0));
    if (m_en && q.size() > 0) chk("out_data", 32'(out_data), 32'(q[0]));
    chk("irq", 32'(irq), 32'(m_irq));
    chk("read_data", read_data, m_rd);
  endtask

  task automatic wr_reg(logic [1:0] a, logic [31:0] d, bit rdy = 0);
    cyc(1, 1, 0, a, d, rdy);
  endtask
  task automatic rd_reg(logic [1:0] a, bit rdy = 0);
    cyc(1, 0, 1, a, 32'd0, rdy);
  endtask
  task automatic idle(bit rdy);
    cyc(0, 0, 0, 2'd0, 32'd0, rdy);
  endtask

  task automatic reset_checks(string tag);
    chk({tag, " rst out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " rst read_data"}, read_data, 32'd0);
    chk({tag, " rst irq"}, 32'(irq), 32'd0);
  endtask

  typedef struct {
    bit          wr;
    bit          rd;
    logic [1:0]  a;
    logic [31:0] d;
    bit          has_exp;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [31:0] d;
    logic [1:0]  a;
    int          r, pct;

    tbl[0]  = '{0, 1, 2'd2, 32'h0,        1, 32'h0000_0001};
    tbl[1]  = '{1, 0, 2'd1, 32'h3,        0, 32'h0};
    tbl[2]  = '{0, 1, 2'd1, 32'h0,        1, 32'h0000_0003};
    tbl[3]  = '{1, 0, 2'd1, 32'h0,        0, 32'h0};
    tbl[4]  = '{0, 1, 2'd0, 32'h0,        1, 32'h0};
    tbl[5]  = '{1, 0, 2'd0, 32'h111,      0, 32'h0};
    tbl[6]  = '{0, 1, 2'd2, 32'h0,        1, 32'h0000_0100};
    tbl[7]  = '{1, 0, 2'd1, 32'h4,        0, 32'h0};
    tbl[8]  = '{0, 1, 2'd2, 32'h0,        1, 32'h0000_0001};
    tbl[9]  = '{1, 0, 2'd3, 32'hFFFF_FFFF, 0, 32'h0};
    tbl[10] = '{0, 1, 2'd3, 32'h0,        1, 32'h0};
    tbl[11] = '{0, 1, 2'd1, 32'h0,        1, 32'h0};

    // 1: reset state
    model_reset();
    repeat (3) @(negedge clk);
    reset_checks("t1");
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      cyc(1, tbl[i].wr, tbl[i].rd, tbl[i].a, tbl[i].d, 0);
      if (tbl[i].has_exp) chk($sformatf("vec%0d", i), read_data, tbl[i].exp);
    end

    // 2: show-ahead hold, then back-to-back drain
    wr_reg(2'd1, 32'h1);
    wr_reg(2'd0, 32'h0123_4567);
    wr_reg(2'd0, 32'h0ABC_DEF0);
    repeat (3) begin
      idle(0);
      chk("t2 hold valid", 32'(out_valid), 32'd1);
      chk("t2 hold data", 32'(out_data), 32'h0123_4567);
    end
    idle(1);
    chk("t2 second valid", 32'(out_valid), 32'd1);
    chk("t2 second data", 32'(out_data), 32'h0ABC_DEF0);
    idle(1);
    chk("t2 drained", 32'(out_valid), 32'd0);
    idle(0);

    // 3: overflow on the 17th sample, W1C, 17th never streamed
    wr_reg(2'd1, 32'h0);
    for (int i = 0; i < 17; i++) wr_reg(2'd0, 32'h00A0_0000 + i);
    rd_reg(2'd2);
    chk("t3 stat full ovf", read_data, 32'h0000_100A);
    wr_reg(2'd2, 32'h8);
    rd_reg(2'd2);
    chk("t3 stat w1c", read_data, 32'h0000_1002);
    wr_reg(2'd1, 32'h1);
    for (int i = 0; i < 16; i++) begin
      chk("t3 order", 32'(out_data), 32'h00A0_0000 + i);
      idle(1);
    end
    chk("t3 no 17th", 32'(out_valid), 32'd0);
    idle(0);
    wr_reg(2'd1, 32'h0);

    // 4: push into a full FIFO during a pop
    for (int i = 0; i < 16; i++) wr_reg(2'd0, 32'h00B0_0000 + i);
    wr_reg(2'd1, 32'h1);
    wr_reg(2'd0, 32'h05A5_A5A5, 1);
    rd_reg(2'd2);
    chk("t4 stat no ovf", read_data, 32'h0000_1002);
    repeat (15) idle(1);
    chk("t4 tail sample", 32'(out_data), 32'h05A5_A5A5);
    idle(1);
    idle(0);
    wr_reg(2'd1, 32'h0);

    // 5: low-water irq with 1-cycle lag, then underrun
    for (int i = 0; i < 5; i++) wr_reg(2'd0, 32'h00C0_0000 + i);
    wr_reg(2'd1, 32'h3);
    idle(0); idle(0);
    chk("t5 irq above low", 32'(irq), 32'd0);
    idle(1);
    chk("t5 irq lag", 32'(irq), 32'd0);
    idle(0);
    chk("t5 irq at low", 32'(irq), 32'd1);
    repeat (4) idle(1);
    idle(1);
    idle(0);
    rd_reg(2'd2);
    chk("t5 stat underrun", read_data, 32'h0000_0005);
    wr_reg(2'd2, 32'hC);
    wr_reg(2'd1, 32'h0);

    // 6: flush with a pop in the same cycle, then async reset mid-stream
    for (int i = 0; i < 8; i++) wr_reg(2'd0, 32'h00D0_0000 + i);
    wr_reg(2'd1, 32'h1);
    wr_reg(2'd1, 32'h5, 1);
    chk("t6 flushed", 32'(out_valid), 32'd0);
    rd_reg(2'd2);
    chk("t6 stat empty", read_data, 32'h0000_0001);
    wr_reg(2'd0, 32'h0000_0123);
    wr_reg(2'd0, 32'h0000_0456);
    chk("t6 streaming", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("t6 async drop", 32'(out_valid), 32'd0);
    model_reset();
    chipselect = 0; write = 0; read = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    reset_checks("t6");
    rst_n = 1'b1;
    rd_reg(2'd2);
    chk("t6 stat after rst", read_data, 32'h0000_0001);

    // Randomized traffic against the model, ready density varied per phase
    for (int i = 0; i < 900; i++) begin
      pct = (i / 150) % 3 == 0 ? 15 : ((i / 150) % 3 == 1 ? 50 : 90);
      r = $urandom_range(0, 9);
      a = r < 5 ? 2'd0 : (r < 7 ? 2'd1 : (r < 9 ? 2'd2 : 2'd3));
      d = $urandom;
      if (a == 2'd1) begin
        d[2] = ($urandom_range(0, 15) == 0);
        d[0] = ($urandom_range(0, 3) != 0);
      end
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 2) == 0, a, d, $urandom_range(0, 99) < pct);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
